ticker_scroll_ctrl: RTL and testbench

TICKER_SCROLL_CTRL -- requirements
Module: ticker_scroll_ctrl

---
 rtl/ticker_scroll_ctrl.sv | 141 ++++++++++++++
 tb/tb_ticker_scroll_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ticker_scroll_ctrl.sv
// Scrolling ticker controller: loads a short message of 4-bit codes, then
// multiplexes it across eight active-low digits while stepping the scroll offset.
module ticker_scroll_ctrl #(
    parameter int         SCAN_DIV = 50000,
    parameter int         STEP_DIV = 64,
    parameter logic [3:0] BLANK    = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       run,
    input  logic       load,
    input  logic       wr_valid,
    input  logic [3:0] wr_data,
    input  logic       wr_last,
    output logic       wr_ready,
    output logic [7:0] enable,
    output logic [3:0] code,
    output logic       scrolling
);

    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [3:0]       buf_q [16];
    logic [4:0]       len_q, len_d;
    logic [3:0]       wr_ptr_q, wr_ptr_d;
    logic [3:0]       offset_q, offset_d;
    logic [2:0]       dig_q, dig_d;
    logic [7:0]       enable_q, enable_d;
    logic [SCW-1:0]   scan_q, scan_d;
    logic [STW-1:0]   step_q, step_d;

    logic       scan_tick, step_tick, wr_fire, wr_final;
    logic [4:0] off_plus, len_m1, sum, idx;
    logic [3:0] offset_inc, offset_dec;

    assign scan_tick = (scan_q == SCW'(SCAN_DIV - 1));
    assign step_tick = (state_q == S_RUN) && scan_tick && (step_q == STW'(STEP_DIV - 1));
    // load wins over any write in the same cycle, including the final one
    assign wr_fire   = (state_q == S_LOAD) && wr_valid && !load;
    assign wr_final  = wr_fire && (wr_last || (wr_ptr_q == 4'd15));

    assign off_plus   = {1'b0, offset_q} + 5'd1;
    assign len_m1     = len_q - 5'd1;
    assign offset_inc = (off_plus == len_q) ? 4'd0 : off_plus[3:0];
    assign offset_dec = (offset_q == 4'd0) ? len_m1[3:0] : offset_q - 4'd1;

    assign sum       = {1'b0, offset_q} + {2'b00, dig_q};
    assign idx       = (len_q == 5'd0) ? 5'd0 : (sum % len_q);
    assign code      = (state_q == S_LOAD) ? BLANK : buf_q[idx[3:0]];
    assign wr_ready  = (state_q == S_LOAD);
    assign scrolling = (state_q == S_RUN);
    assign enable    = enable_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        offset_d = offset_q;
        dig_d    = dig_q;
        enable_d = enable_q;
        step_d   = step_q;
        scan_d   = scan_tick ? '0 : scan_q + SCW'(1);

        if (scan_tick) begin
            dig_d    = dig_q + 3'd1;
            enable_d = ~(8'd1 << dig_d);
        end

        case (state_q)
            S_LOAD: begin
                step_d = '0;
                if (load) begin
                    wr_ptr_d = 4'd0;
                end else if (wr_fire) begin
                    wr_ptr_d = wr_ptr_q + 4'd1;
                    if (wr_final) begin
                        len_d    = {1'b0, wr_ptr_q} + 5'd1;
                        offset_d = 4'd0;
                        state_d  = run ? S_RUN : S_HOLD;
                    end
                end
            end
            S_RUN: begin
                if (load) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = 4'd0;
                    offset_d = 4'd0;
                    step_d   = '0;
                end else begin
                    if (scan_tick) step_d = step_tick ? '0 : step_q + STW'(1);
                    if (step_tick) offset_d = up ? offset_inc : offset_dec;
                    if (!run) state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (load) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = 4'd0;
                    offset_d = 4'd0;
                    step_d   = '0;
                end else if (run) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_LOAD;
            len_q    <= 5'd0;
            wr_ptr_q <= 4'd0;
            offset_q <= 4'd0;
            dig_q    <= 3'd0;
            enable_q <= 8'hFE;
            scan_q   <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            offset_q <= offset_d;
            dig_q    <= dig_d;
            enable_q <= enable_d;
            scan_q   <= scan_d;
            step_q   <= step_d;
        end
    end

    // Message storage is only readable after a completed load, so it has no reset
    always_ff @(posedge clk) begin
        if (wr_fire) buf_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_ticker_scroll_ctrl.sv
// Bench for ticker_scroll_ctrl: cycle model of message/offset/digit behaviour
// compared every cycle, plus literal digit checks for known messages.
module tb_ticker_scroll_ctrl;

    localparam int SD = 2;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b1, run = 1'b0, load = 1'b0;
    logic       wr_valid = 1'b0, wr_last = 1'b0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_ready, scrolling;
    logic [7:0] enable;
    logic [3:0] code;

    ticker_scroll_ctrl #(.SCAN_DIV(SD), .STEP_DIV(TD), .BLANK(4'hF)) dut (
        .clk(clk), .rst(rst), .up(up), .run(run), .load(load),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .enable(enable), .code(code), .scrolling(scrolling)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = loading, 1 = scrolling, 2 = frozen
    int m_st, m_len, m_wp, m_off, m_cyc, m_dig, m_steps;
    int m_msg [16];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_len = 0; m_wp = 0; m_off = 0;
            m_cyc = 0; m_dig = 0; m_steps = 0;
        end else begin
            bit scan, stepnow;
            scan    = (m_cyc % SD) == SD - 1;
            stepnow = (m_st == 1) && scan && ((m_steps % TD) == TD - 1);
            m_cyc++;
            if (scan) m_dig = (m_dig + 1) % 8;
            if (m_st == 0) begin
                m_steps = 0;
                if (load) m_wp = 0;
                else if (wr_valid) begin
                    m_msg[m_wp] = int'(wr_data);
                    if (wr_last || m_wp == 15) begin
                        m_len = m_wp + 1;
                        m_off = 0;
                        m_st  = run ? 1 : 2;
                    end
                    m_wp = (m_wp + 1) % 16;
                end
            end else if (load) begin
                m_st = 0; m_wp = 0; m_off = 0; m_steps = 0;
            end else if (m_st == 1) begin
                if (scan) m_steps++;
                if (stepnow) m_off = up ? (m_off + 1) % m_len : (m_off + m_len - 1) % m_len;
                if (!run) m_st = 2;
            end else if (run) begin
                m_st = 1;
            end
        end
    end

    function automatic logic [3:0] exp_code();
        if (m_st == 0 || m_len == 0) return 4'hF;
        return 4'(m_msg[(m_off + m_dig) % m_len]);
    endfunction

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            logic [7:0] e;
            e = ~(8'd1 << m_dig);
            check("wr_ready", wr_ready, m_st == 0);
            check("scrolling", scrolling, m_st == 1);
            check("enable", enable, e);
            check("code", code, exp_code());
        end
    end

    task automatic send(input logic [3:0] d, input logic last);
        wr_valid = 1'b1; wr_data = d; wr_last = last;
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_digit(input int idx, input logic [3:0] exp, input string name);
        logic [7:0] tgt;
        int n;
        tgt = ~(8'd1 << idx);
        n = 0;
        while (enable !== tgt && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (enable !== tgt) check({name, "_timeout"}, enable, tgt);
        else check(name, code, exp);
    endtask

    task automatic wait_off(input int target, input string name);
        int n;
        n = 0;
        while (m_off != target && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (m_off != target) check({name, "_timeout"}, m_off, target);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_enable", enable, 8'hFE);
        check("rst_code", code, 4'hF);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_scrolling", scrolling, 1'b0);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // three-character message, repeating across digits
        pulse_load();
        run = 1'b1; up = 1'b1;
        send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b1);
        check("run_scrolling", scrolling, 1'b1);
        check("run_wr_ready", wr_ready, 1'b0);
        run = 1'b0;
        @(negedge clk);
        check_digit(0, 4'd1, "msg3_d0");
        check_digit(1, 4'd2, "msg3_d1");
        check_digit(2, 4'd3, "msg3_d2");
        check_digit(3, 4'd1, "msg3_d3");

        // one step left
        run = 1'b1;
        wait_off(1, "step_left");
        run = 1'b0;
        @(negedge clk);
        check_digit(0, 4'd2, "left_d0");
        check_digit(1, 4'd3, "left_d1");

        // one step right from offset 0 wraps to the last character
        pulse_load();
        send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b1);
        up = 1'b0; run = 1'b1;
        wait_off(2, "step_right");
        run = 1'b0;
        @(negedge clk);
        check_digit(0, 4'd3, "right_d0");
        check_digit(1, 4'd1, "right_d1");

        // sixteen writes without wr_last fill the buffer and end loading
        pulse_load();
        run = 1'b1; up = 1'b1;
        for (int i = 0; i < 16; i++) send(4'(15 - i), 1'b0);
        check("full_wr_ready", wr_ready, 1'b0);
        check("full_scrolling", scrolling, 1'b1);
        wr_valid = 1'b1; wr_data = 4'd7;
        repeat (2) @(negedge clk);
        check("extra_write_ready", wr_ready, 1'b0);
        wr_valid = 1'b0;
        repeat (30) @(negedge clk);

        // hold for 20 scan ticks, resume, then reverse direction
        run = 1'b0;
        repeat (40) @(negedge clk);
        run = 1'b1;
        repeat (30) @(negedge clk);
        up = 1'b0;
        repeat (30) @(negedge clk);

        // load lands on the same edge as a step
        begin
            int n;
            n = 0;
            while (!(m_st == 1 && (m_cyc % SD) == SD - 1 && (m_steps % TD) == TD - 1) && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check("find_step_timeout", n, 0);
        end
        pulse_load();
        check("load_step_wr_ready", wr_ready, 1'b1);
        check("load_step_code", code, 4'hF);
        check("load_step_scrolling", scrolling, 1'b0);

        // final write together with load is dropped and the pointer restarts
        wr_valid = 1'b1; wr_data = 4'd9; wr_last = 1'b1; load = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0; load = 1'b0;
        check("load_final_wr_ready", wr_ready, 1'b1);
        run = 1'b0;
        send(4'd5, 1'b0); send(4'd6, 1'b1);
        check_digit(0, 4'd5, "restart_d0");
        check_digit(1, 4'd6, "restart_d1");
        check_digit(2, 4'd5, "restart_d2");

        // asynchronous reset pulse between edges
        run = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_enable", enable, 8'hFE);
        check("async_code", code, 4'hF);
        check("async_wr_ready", wr_ready, 1'b1);
        check("async_scrolling", scrolling, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        send(4'd9, 1'b1);
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
